// File: rtl/pcint_ctrl_if.sv
`default_nettype none
// ============================================================================
// pcint_ctrl_if : WISHBONE slave bus bundle for the pin-change interrupt block.
// Revision 1.0
// ============================================================================
interface pcint_ctrl_if;
  logic [2:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_we_i;
  logic       wb_stb_i;
  logic       wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface
`default_nettype wire

// File: rtl/pcint_ctrl.sv
`default_nettype none
// ============================================================================
// pcint_ctrl : pin-change interrupt controller for the Arduino I/O pins.
// Revision 1.0
// ============================================================================
module pcint_ctrl #(
  parameter int N          = 14,
  parameter int FILTER_LEN = 0,
  parameter int ENABLE     = 1
) (
  input  wire         wb_clk_i,
  input  wire         wb_rst_i,
  pcint_ctrl_if.slave wb,
  input  wire [N-1:0] pin_i,
  output logic        irq_req_o,
  input  wire         irq_ack_i
);

  if (ENABLE != 0) begin : g_enabled
    localparam logic [15:0] c_MASK = (N >= 16) ? 16'hFFFF : 16'((32'd1 << N) - 32'd1);

    logic [15:0] w_pin;
    logic [15:0] r_s1;
    logic [15:0] r_s2;
    logic [15:0] r_filt;
    logic [15:0] r_prev;
    logic [15:0] r_rise_en;
    logic [15:0] r_fall_en;
    logic [15:0] r_flag;
    logic [15:0] w_set;
    logic [15:0] w_new;
    logic [15:0] w_clr;
    logic        r_pend;
    logic        w_wr;
    logic [7:0]  w_rdata;

    assign w_pin = 16'(pin_i);
    assign w_wr  = wb.wb_stb_i & wb.wb_we_i;

    assign w_clr = (w_wr && wb.wb_adr_i == 3'd4) ? {8'h00, wb.wb_dat_i} :
                   (w_wr && wb.wb_adr_i == 3'd5) ? {wb.wb_dat_i, 8'h00} : 16'h0000;

    assign w_set = ((r_filt & ~r_prev & r_rise_en) | (~r_filt & r_prev & r_fall_en)) & c_MASK;
    // Only bits that are currently clear can raise a new request.
    assign w_new = w_set & ~r_flag;

    // Synchroniser keeps sampling in reset so the filtered state starts at the live level.
    always_ff @(posedge wb_clk_i) begin
      r_s1 <= w_pin;
      r_s2 <= r_s1;
    end

    if (FILTER_LEN == 0) begin : g_bypass
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          r_filt <= r_s1;
        end else begin
          r_filt <= r_s2;
        end
      end
    end else begin : g_filter
      localparam logic [7:0] c_CNT_MAX = 8'(FILTER_LEN - 1);
      logic [7:0] r_cnt [16];

      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          r_filt <= r_s1;
          for (int i = 0; i < 16; i++) begin
            r_cnt[i] <= 8'h00;
          end
        end else begin
          for (int i = 0; i < 16; i++) begin
            if (r_s2[i] == r_filt[i]) begin
              r_cnt[i] <= 8'h00;
            end else if (r_cnt[i] == c_CNT_MAX) begin
              r_filt[i] <= r_s2[i];
              r_cnt[i]  <= 8'h00;
            end else begin
              r_cnt[i] <= r_cnt[i] + 8'd1;
            end
          end
        end
      end
    end

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        r_prev    <= r_s1;
        r_rise_en <= 16'h0000;
        r_fall_en <= 16'h0000;
        r_flag    <= 16'h0000;
        r_pend    <= 1'b0;
      end else begin
        r_prev <= r_filt;
        r_flag <= (r_flag & ~w_clr) | w_set;
        r_pend <= (r_pend & ~irq_ack_i) | (|w_new);
        if (w_wr) begin
          case (wb.wb_adr_i)
            3'd0:    r_rise_en[7:0]  <= wb.wb_dat_i & c_MASK[7:0];
            3'd1:    r_rise_en[15:8] <= wb.wb_dat_i & c_MASK[15:8];
            3'd2:    r_fall_en[7:0]  <= wb.wb_dat_i & c_MASK[7:0];
            3'd3:    r_fall_en[15:8] <= wb.wb_dat_i & c_MASK[15:8];
            default: ;
          endcase
        end
      end
    end

    always_comb begin
      w_rdata = 8'h00;
      case (wb.wb_adr_i)
        3'd0: w_rdata = r_rise_en[7:0];
        3'd1: w_rdata = r_rise_en[15:8];
        3'd2: w_rdata = r_fall_en[7:0];
        3'd3: w_rdata = r_fall_en[15:8];
        3'd4: w_rdata = r_flag[7:0];
        3'd5: w_rdata = r_flag[15:8];
        3'd6: w_rdata = r_filt[7:0] & c_MASK[7:0];
        3'd7: w_rdata = r_filt[15:8] & c_MASK[15:8];
      endcase
    end

    assign wb.wb_dat_o = w_rdata;
    assign wb.wb_ack_o = wb.wb_stb_i;
    assign irq_req_o   = r_pend;
  end else begin : g_disabled
    assign wb.wb_dat_o = 8'h00;
    assign wb.wb_ack_o = 1'b0;
    assign irq_req_o   = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_pcint_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pcint_ctrl : directed bench for pcint_ctrl, unfiltered (A) and FILTER_LEN=4 (B).
// Revision 1.0
// ============================================================================
module tb_pcint_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] pa;
  logic [13:0] pb;
  logic        ack_a;
  logic        ack_b;
  logic        irq_a;
  logic        irq_b;
  int          n_tests = 0;
  int          n_fail  = 0;

  pcint_ctrl_if bus_a ();
  pcint_ctrl_if bus_b ();

  pcint_ctrl #(.N(14), .FILTER_LEN(0), .ENABLE(1)) u_a (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus_a),
    .pin_i    (pa),
    .irq_req_o(irq_a),
    .irq_ack_i(ack_a)
  );

  pcint_ctrl #(.N(14), .FILTER_LEN(4), .ENABLE(1)) u_b (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus_b),
    .pin_i    (pb),
    .irq_req_o(irq_b),
    .irq_ack_i(ack_b)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic rd(input bit sel, input logic [2:0] a, output logic [7:0] d);
    if (!sel) begin
      bus_a.wb_adr_i = a; bus_a.wb_we_i = 1'b0; bus_a.wb_stb_i = 1'b1;
      #1 d = bus_a.wb_dat_o;
      bus_a.wb_stb_i = 1'b0;
    end else begin
      bus_b.wb_adr_i = a; bus_b.wb_we_i = 1'b0; bus_b.wb_stb_i = 1'b1;
      #1 d = bus_b.wb_dat_o;
      bus_b.wb_stb_i = 1'b0;
    end
  endtask

  task automatic chk_rd(input bit sel, input logic [2:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    rd(sel, a, d);
    chk(tag, d, exp);
  endtask

  task automatic wr(input bit sel, input logic [2:0] a, input logic [7:0] d);
    if (!sel) begin
      bus_a.wb_adr_i = a; bus_a.wb_dat_i = d; bus_a.wb_we_i = 1'b1; bus_a.wb_stb_i = 1'b1;
    end else begin
      bus_b.wb_adr_i = a; bus_b.wb_dat_i = d; bus_b.wb_we_i = 1'b1; bus_b.wb_stb_i = 1'b1;
    end
    @(negedge clk);
    bus_a.wb_we_i = 1'b0; bus_a.wb_stb_i = 1'b0;
    bus_b.wb_we_i = 1'b0; bus_b.wb_stb_i = 1'b0;
  endtask

  task automatic ack_pulse_a();
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pa = 14'h3FFF; pb = 14'h3FFF;
    ack_a = 1'b0; ack_b = 1'b0;
    bus_a.wb_adr_i = 3'd0; bus_a.wb_dat_i = 8'h00; bus_a.wb_we_i = 1'b0; bus_a.wb_stb_i = 1'b0;
    bus_b.wb_adr_i = 3'd0; bus_b.wb_dat_i = 8'h00; bus_b.wb_we_i = 1'b0; bus_b.wb_stb_i = 1'b0;
    tick(3);

    // Reset state
    chk("rst_irq_a", {7'b0, irq_a}, 8'h00);
    chk("rst_ack_a", {7'b0, bus_a.wb_ack_o}, 8'h00);
    chk_rd(0, 3'd0, 8'h00, "rst_rise_l");
    chk_rd(0, 3'd3, 8'h00, "rst_fall_h");
    chk_rd(0, 3'd4, 8'h00, "rst_flag_l");
    chk_rd(0, 3'd6, 8'hFF, "rst_pin_l");
    chk_rd(0, 3'd7, 8'h3F, "rst_pin_h");
    chk_rd(1, 3'd7, 8'h3F, "rst_pin_h_b");
    rst = 1'b0;
    tick(1);

    bus_a.wb_stb_i = 1'b1;
    #1 chk("ack_follows_stb", {7'b0, bus_a.wb_ack_o}, 8'h01);
    bus_a.wb_stb_i = 1'b0;

    // Test 1: enabling everything with stable pins creates nothing
    for (int i = 0; i < 4; i++) wr(0, 3'(i), 8'hFF);
    chk_rd(0, 3'd1, 8'h3F, "rise_h_masked");
    wr(0, 3'd6, 8'h00);
    chk_rd(0, 3'd6, 8'hFF, "pin_l_readonly");
    tick(20);
    chk_rd(0, 3'd4, 8'h00, "t1_flag_l");
    chk_rd(0, 3'd5, 8'h00, "t1_flag_h");
    chk("t1_irq", {7'b0, irq_a}, 8'h00);

    wr(0, 3'd0, 8'h2F); wr(0, 3'd1, 8'h01);
    wr(0, 3'd2, 8'h00); wr(0, 3'd3, 8'h00);
    wr(1, 3'd3, 8'h02);
    pa = 14'h0000;
    tick(6);
    chk_rd(0, 3'd4, 8'h00, "fall_disabled");
    chk("fall_dis_irq", {7'b0, irq_a}, 8'h00);

    // Test 2: rise on pin 0, exact latency, ack, W1C
    pa[0] = 1'b1;
    tick(3);
    chk_rd(0, 3'd4, 8'h00, "t2_flag_k2");
    chk("t2_irq_k2", {7'b0, irq_a}, 8'h00);
    tick(1);
    chk_rd(0, 3'd4, 8'h01, "t2_flag_k3");
    chk("t2_irq_k3", {7'b0, irq_a}, 8'h01);
    ack_pulse_a();
    chk("t2_irq_ack", {7'b0, irq_a}, 8'h00);
    chk_rd(0, 3'd4, 8'h01, "t2_flag_after_ack");
    wr(0, 3'd4, 8'h01);
    chk_rd(0, 3'd4, 8'h00, "t2_w1c");

    // Test 4: set beats W1C; event beats ack
    pa[2] = 1'b1;
    tick(3);
    wr(0, 3'd4, 8'h04);
    chk_rd(0, 3'd4, 8'h04, "t4_set_wins");
    chk("t4_irq", {7'b0, irq_a}, 8'h01);
    pa[3] = 1'b1;
    tick(3);
    ack_a = 1'b1;
    tick(1);
    ack_a = 1'b0;
    chk("t4_event_beats_ack", {7'b0, irq_a}, 8'h01);
    chk_rd(0, 3'd4, 8'h0C, "t4_flag");

    // Test 5: event on an already-set flag does not re-arm the request
    ack_pulse_a();
    chk("t5_irq_acked", {7'b0, irq_a}, 8'h00);
    pa[3] = 1'b0;
    tick(5);
    pa[3] = 1'b1;
    tick(5);
    chk("t5_no_rearm", {7'b0, irq_a}, 8'h00);
    chk_rd(0, 3'd4, 8'h0C, "t5_flag");
    pa[5] = 1'b1;
    tick(5);
    chk("t5_rearm", {7'b0, irq_a}, 8'h01);
    chk_rd(0, 3'd4, 8'h2C, "t5_flag5");

    // Test 3: glitch filter on B, pin 9 falling
    pb[9] = 1'b0;
    tick(3);
    pb[9] = 1'b1;
    tick(10);
    chk_rd(1, 3'd5, 8'h00, "t3_glitch_flag");
    chk_rd(1, 3'd7, 8'h3F, "t3_glitch_pin");
    chk("t3_glitch_irq", {7'b0, irq_b}, 8'h00);
    pb[9] = 1'b0;
    tick(5);
    chk_rd(1, 3'd7, 8'h3F, "t3_pin_k4");
    tick(1);
    chk_rd(1, 3'd5, 8'h00, "t3_flag_k5");
    tick(2);
    chk_rd(1, 3'd5, 8'h02, "t3_flag_k7");
    chk_rd(1, 3'd7, 8'h3D, "t3_pin_low");
    chk("t3_irq", {7'b0, irq_b}, 8'h01);
    tick(4);
    pb[9] = 1'b1;
    tick(10);
    chk_rd(1, 3'd7, 8'h3F, "t3_pin_high");
    chk_rd(1, 3'd5, 8'h02, "t3_flag_kept");

    // Test 6: reset mid-operation with FLAG=0x0103 and request high
    ack_pulse_a();
    wr(0, 3'd4, 8'hFF);
    pa[0] = 1'b0;
    tick(5);
    pa[0] = 1'b1; pa[1] = 1'b1; pa[8] = 1'b1;
    tick(5);
    chk_rd(0, 3'd4, 8'h03, "t6_flag_l");
    chk_rd(0, 3'd5, 8'h01, "t6_flag_h");
    chk("t6_irq", {7'b0, irq_a}, 8'h01);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_rst_irq", {7'b0, irq_a}, 8'h00);
    for (int i = 0; i < 6; i++) chk_rd(0, 3'(i), 8'h00, "t6_rst_reg");
    tick(5);
    chk("t6_post_irq", {7'b0, irq_a}, 8'h00);
    chk_rd(0, 3'd4, 8'h00, "t6_post_flag");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
